// File: rtl/move_gen_pkg.sv
// Shared types and constants for the labyrinth movement-pulse generator.
package move_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_ACCUM,
    ST_EMIT
  } state_e;

  localparam int unsigned RIGHT = 3;
  localparam int unsigned LEFT  = 2;
  localparam int unsigned DOWN  = 1;
  localparam int unsigned UP    = 0;

  localparam int unsigned ACCEL_CENTER = 256;
  localparam int unsigned SPEED_MAX    = 63;
  localparam int unsigned FRAC_BITS    = 4;

  localparam int unsigned ACCEL_W = 9;
  localparam int unsigned DIR_W   = 4;
  localparam int unsigned TILT_W  = 10;
  localparam int unsigned SPEED_W = 6;
  localparam int unsigned SUM_W   = 7;
  localparam int unsigned PEND_W  = 3;

endpackage

// File: rtl/move_gen_if.sv
// Input/output bundle between the control sources and move_gen.
interface move_gen_if;
  import move_gen_pkg::*;

  logic [DIR_W-1:0]   btn;
  logic [ACCEL_W-1:0] accel_x;
  logic [ACCEL_W-1:0] accel_y;
  logic               freeze;
  logic [DIR_W-1:0]   movement;
  logic               frame_tick;
  logic               busy;

  modport master (
    output btn, accel_x, accel_y, freeze,
    input  movement, frame_tick, busy
  );

  modport slave (
    input  btn, accel_x, accel_y, freeze,
    output movement, frame_tick, busy
  );

endinterface

// File: rtl/move_gen_axis_stepper.sv
// One axis: speed selection (buttons over tilt), fractional accumulator and pending pulse count.
// The tilt path exists only when MOVE_GEN_ACCEL_EN is defined.
module axis_stepper
  import move_gen_pkg::*;
#(
  parameter int unsigned DEADZONE   = 16,
  parameter int unsigned GAIN_SHIFT = 1,
  parameter int unsigned BTN_SPEED  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_pos,
  input  logic               i_neg,
  input  logic [ACCEL_W-1:0] i_accel,
  input  logic               i_freeze,
  input  logic               i_load,
  input  logic               i_issue,
  output logic [1:0]         o_req_c,
  output logic               o_idle_c
);

  logic [FRAC_BITS-1:0] r_frac;
  logic                 r_dir;
  logic [PEND_W-1:0]    r_pend;

  logic [SPEED_W-1:0]   w_tilt_speed;
  logic                 w_tilt_neg;
  logic [SPEED_W-1:0]   w_speed;
  logic                 w_dir;
  logic [FRAC_BITS-1:0] w_frac_base;
  logic [SUM_W-1:0]     w_sum;
  logic [PEND_W-1:0]    w_pend_calc;

`ifdef MOVE_GEN_ACCEL_EN
  logic [TILT_W-1:0] w_tilt;
  logic [TILT_W-1:0] w_mag;
  logic [TILT_W-1:0] w_excess;

  // Offset-binary tilt to magnitude/sign, then deadzone, gain and clamp
  always_comb begin
    w_tilt       = TILT_W'(i_accel) - TILT_W'(ACCEL_CENTER);
    w_tilt_neg   = w_tilt[TILT_W-1];
    w_mag        = w_tilt_neg ? (~w_tilt + TILT_W'(1)) : w_tilt;
    w_excess     = (w_mag - TILT_W'(DEADZONE)) >> GAIN_SHIFT;
    w_tilt_speed = '0;
    if (w_mag <= TILT_W'(DEADZONE))
      w_tilt_speed = '0;
    else if (w_excess > TILT_W'(SPEED_MAX))
      w_tilt_speed = SPEED_W'(SPEED_MAX);
    else
      w_tilt_speed = SPEED_W'(w_excess);
  end
`else
  logic w_unused_tilt;
  assign w_unused_tilt = ^{i_accel, 8'(DEADZONE), 8'(GAIN_SHIFT)};
  assign w_tilt_speed  = '0;
  assign w_tilt_neg    = 1'b0;
`endif

  // A single held button overrides tilt; both held cancel the axis
  always_comb begin
    w_speed = w_tilt_speed;
    w_dir   = w_tilt_neg;
    if (i_pos ^ i_neg) begin
      w_speed = SPEED_W'(BTN_SPEED);
      w_dir   = i_neg;
    end else if (i_pos & i_neg) begin
      w_speed = '0;
      w_dir   = r_dir;
    end
    w_frac_base = ((w_speed != '0) && (w_dir != r_dir)) ? '0 : r_frac;
    w_sum       = SUM_W'(w_frac_base) + SUM_W'(w_speed);
    w_pend_calc = i_freeze ? '0 : w_sum[SUM_W-1:FRAC_BITS];
    o_idle_c    = (r_pend == '0);
    o_req_c     = 2'b00;
    if (i_load && (w_pend_calc != '0))
      o_req_c = w_dir ? 2'b01 : 2'b10;
    else if (i_issue && (r_pend != '0))
      o_req_c = r_dir ? 2'b01 : 2'b10;
  end

  // The first pulse leaves during the load cycle, so it is not kept as pending
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frac <= '0;
      r_dir  <= 1'b0;
      r_pend <= '0;
    end else if (i_load) begin
      if (i_freeze) begin
        r_frac <= '0;
        r_pend <= '0;
      end else begin
        r_frac <= w_sum[FRAC_BITS-1:0];
        if (w_speed != '0)
          r_dir <= w_dir;
        r_pend <= (w_pend_calc != '0) ? (w_pend_calc - PEND_W'(1)) : '0;
      end
    end else if (i_issue && (r_pend != '0)) begin
      r_pend <= r_pend - PEND_W'(1);
    end
  end

endmodule

// File: rtl/move_gen.sv
// Frame-rate movement-pulse generator: frame counter, sequencing FSM and output registers.
// Optional tilt input path enabled by MOVE_GEN_ACCEL_EN.
module move_gen
  import move_gen_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned FRAME_HZ   = 60,
  parameter int unsigned DEADZONE   = 16,
  parameter int unsigned GAIN_SHIFT = 1,
  parameter int unsigned BTN_SPEED  = 16
) (
  input logic       clk,
  input logic       reset,
  move_gen_if.slave bus
);

  localparam int unsigned P     = CLK_HZ / FRAME_HZ;
  localparam int unsigned CNT_W = $clog2(P);

  state_e             r_state;
  state_e             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_tick;
  logic               r_busy;
  logic               r_phase;
  logic [DIR_W-1:0]   r_movement;
  logic [DIR_W-1:0]   r_btn;
  logic [ACCEL_W-1:0] r_ax;
  logic [ACCEL_W-1:0] r_ay;
  logic               r_frz;

  logic w_sample;
  logic w_load;
  logic w_issue;
  logic [1:0] w_x_req;
  logic [1:0] w_y_req;
  logic w_x_idle;
  logic w_y_idle;

  axis_stepper #(.DEADZONE(DEADZONE), .GAIN_SHIFT(GAIN_SHIFT), .BTN_SPEED(BTN_SPEED)) u_axis_x (
    .clk      (clk),
    .reset    (reset),
    .i_pos    (r_btn[RIGHT]),
    .i_neg    (r_btn[LEFT]),
    .i_accel  (r_ax),
    .i_freeze (r_frz),
    .i_load   (w_load),
    .i_issue  (w_issue),
    .o_req_c  (w_x_req),
    .o_idle_c (w_x_idle)
  );

  axis_stepper #(.DEADZONE(DEADZONE), .GAIN_SHIFT(GAIN_SHIFT), .BTN_SPEED(BTN_SPEED)) u_axis_y (
    .clk      (clk),
    .reset    (reset),
    .i_pos    (r_btn[DOWN]),
    .i_neg    (r_btn[UP]),
    .i_accel  (r_ay),
    .i_freeze (r_frz),
    .i_load   (w_load),
    .i_issue  (w_issue),
    .o_req_c  (w_y_req),
    .o_idle_c (w_y_idle)
  );

  // Next-state and per-state strobes; pulses go out on every other EMIT cycle
  always_comb begin
    w_next   = r_state;
    w_sample = 1'b0;
    w_load   = 1'b0;
    w_issue  = 1'b0;
    unique case (r_state)
      ST_IDLE:   if (r_tick) w_next = ST_SAMPLE;
      ST_SAMPLE: begin
        w_sample = 1'b1;
        w_next   = ST_ACCUM;
      end
      ST_ACCUM: begin
        w_load = 1'b1;
        w_next = ST_EMIT;
      end
      ST_EMIT: begin
        w_issue = r_phase;
        if (w_x_idle && w_y_idle) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_tick     <= 1'b0;
      r_busy     <= 1'b0;
      r_phase    <= 1'b0;
      r_movement <= '0;
      r_btn      <= '0;
      r_ax       <= ACCEL_W'(ACCEL_CENTER);
      r_ay       <= ACCEL_W'(ACCEL_CENTER);
      r_frz      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_cnt == CNT_W'(P - 1)) ? '0 : r_cnt + CNT_W'(1);
      r_tick  <= (r_cnt == CNT_W'(P - 2));
      r_busy  <= (w_next != ST_IDLE);
      r_phase <= w_load ? 1'b0 : ((r_state == ST_EMIT) ? ~r_phase : r_phase);
      r_movement[RIGHT] <= w_x_req[1];
      r_movement[LEFT]  <= w_x_req[0];
      r_movement[DOWN]  <= w_y_req[1];
      r_movement[UP]    <= w_y_req[0];
      if (w_sample) begin
        r_btn <= bus.btn;
        r_ax  <= bus.accel_x;
        r_ay  <= bus.accel_y;
        r_frz <= bus.freeze;
      end
    end
  end

  assign bus.movement   = r_movement;
  assign bus.frame_tick = r_tick;
  assign bus.busy       = r_busy;

endmodule

// File: doc/move_gen.md
# move_gen

Movement-pulse generator for the labyrinth ball. It sits directly upstream of the ball module and drives its 4-bit `movement` input. It converts debounced direction buttons, and optionally accelerometer tilt, into rate-controlled single-cycle step pulses. Pulses are issued once per frame tick, and a fractional accumulator gives sub-pixel speeds.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, system clock frequency.
- `FRAME_HZ`, 60, update rate. Period P = CLK_HZ/FRAME_HZ cycles, P ≥ 16.
- `DEADZONE`, 16, tilt magnitude at or below which the axis speed is zero.
- `GAIN_SHIFT`, 1, right shift applied to tilt beyond the deadzone.
- `BTN_SPEED`, 16, button speed in 1/16 px/frame, range 0..63.

Ports:
- `clk` in 1: system clock. One clock domain only.
- `reset` in 1: asynchronous, active-low reset.
- `btn` in 4: debounced buttons {right, left, down, up}.
- `accel_x` in 9: offset binary, 256 = level.
- `accel_y` in 9: offset binary, 256 = level.
- `freeze` in 1: suppresses all motion.
- `movement` out 4: step pulses {right, left, down, up}, each one cycle wide.
- `frame_tick` out 1: one-cycle strobe every P cycles.
- `busy` out 1: high while in any state other than IDLE.

## Operation
- The frame counter runs 0..P-1. `frame_tick` is asserted in the cycle the counter wraps.
- FSM states: IDLE → SAMPLE → ACCUM → EMIT → IDLE.
  - IDLE → SAMPLE on `frame_tick`.
  - SAMPLE registers `btn`, `accel_x`, `accel_y` and `freeze`.
  - ACCUM computes speeds and pending pulse counts.
  - EMIT returns to IDLE once both pending counts reach 0.
- Tilt: t = accel − 256, 10-bit signed. mag = |t|, range 0..256.
- Tilt speed: 0 if mag ≤ DEADZONE, else min((mag − DEADZONE) >> GAIN_SHIFT, 63).
- Sign convention:
  - X axis: positive = right, negative = left.
  - Y axis: positive = down, negative = up.
- Button override, per axis:
  - Exactly one button of the pair held: speed = BTN_SPEED in that direction, tilt ignored.
  - Both buttons of the pair held: axis speed 0.
- Accumulator, per axis:
  - 4-bit fraction plus the last direction.
  - If the direction differs from the last nonzero direction, clear the fraction first.
  - sum = frac + speed (7 bits, max 78). pending = sum >> 4 (0..4). frac = sum[3:0].
  - Speed 0 leaves the fraction unchanged.
- EMIT: X and Y pulses are issued concurrently. A pulse appears on alternate cycles, starting with the first EMIT cycle. Each pulse decrements that axis's pending count.
- `freeze` sampled high: both fractions cleared, pending forced to 0, no pulses. The counter keeps running.
- Reset values: counter 0, FSM IDLE, fractions 0, pending 0, `movement` 0, `frame_tick` 0, `busy` 0.
- Reset asserted mid-EMIT: `movement` goes to 0 immediately (asynchronous); no residual pulses after release.

## Timing
- Tick at cycle T: SAMPLE at T+1, ACCUM at T+2.
- First pulse at T+3. Further pulses at T+5, T+7, T+9. The last possible pulse is at T+9.
- `busy` is high from T+1 until the cycle after the last pulse, or through T+3 when nothing is pending.
- Maximum rate is 4 pulses per axis per frame.
- `movement` is registered. No combinational path from inputs to outputs.
- Inputs are sampled only in SAMPLE. Changes at any other time are ignored until the next frame.

## Configuration
- `MOVE_GEN_ACCEL_EN` defined: the tilt path is compiled in as described above.
- `MOVE_GEN_ACCEL_EN` undefined:
  - `accel_x` and `accel_y` remain ports but are unused.
  - Tilt speed is constant 0, so only buttons produce motion.
  - DEADZONE and GAIN_SHIFT have no effect.

## Structure
- Shared package `move_gen_pkg` holds:
  - the FSM state enum;
  - direction bit indices RIGHT=3, LEFT=2, DOWN=1, UP=0;
  - constants ACCEL_CENTER=256, SPEED_MAX=63, FRAC_BITS=4.
- One sub-module, `axis_stepper`, instantiated twice (X and Y). It owns speed calculation, the fraction/direction register and the pending counter, and outputs per-direction pulse requests.
- The top level owns the frame counter, FSM and output registers.

## Test plan
Bench settings: CLK_HZ=1600, FRAME_HZ=100 (P=16). Accelerometer inputs 256 unless stated.
- Reset held low with random inputs → `movement`=0, `busy`=0, `frame_tick`=0. After release, first `frame_tick` at cycle 15.
- `btn`=4'b1000 held → exactly one `movement[3]` pulse per frame, at T+3.
- `accel_x`=272 → no pulses. `accel_x`=304 → speed 16 → one right pulse per frame.
- `accel_y`=0 → speed 63 → pulses on bit 0.
  - Frame 1: 3 pulses at T+3, T+5, T+7.
  - Frames 2–4: 4 pulses each.
- `accel_x`=232 → speed 4 → one left pulse every 4th frame. Switching to 280 clears the fraction, and the first right pulse follows 4 frames later.
- `btn`=4'b1100 → no X pulses.
- `freeze`=1 → no pulses.
- Reset asserted at T+5 of a 4-pulse frame → `movement` 0 in the same cycle.
- With `MOVE_GEN_ACCEL_EN` undefined and `accel_y`=0 → no pulses.
